// File: rtl/hazard_stall_unit.sv
// hazard_stall_unit
//   Stall/flush controller for the 5-stage pipeline. Handles the hazards that
//   bypassing cannot resolve: load-use dependencies, taken-branch redirects and
//   multi-cycle execute ops (mul/div) that must hold the Execute stage.
//
// Ports
//   clk       pipeline clock, rising edge
//   rst       asynchronous active-low reset
//   Rs1_D     source register 1 of the Decode instruction
//   Rs2_D     source register 2 of the Decode instruction
//   RD_E      destination register of the Execute instruction
//   MemReadE  Execute instruction is a load
//   PCSrcE    taken branch/jump resolved in Execute
//   MdStartE  Execute instruction is a multi-cycle op (held while in Execute)
//   StallF    hold PC / Fetch register
//   StallD    hold Decode register
//   StallE    hold Execute register
//   FlushD    clear Decode register
//   FlushE    clear Execute register
//   FlushM    clear Memory register (bubble behind held Execute op)
//   MdBusy    multi-cycle sequence in progress
module hazard_stall_unit #(
    parameter int MD_LATENCY = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [4:0] Rs1_D,
    input  logic [4:0] Rs2_D,
    input  logic [4:0] RD_E,
    input  logic       MemReadE,
    input  logic       PCSrcE,
    input  logic       MdStartE,
    output logic       StallF,
    output logic       StallD,
    output logic       StallE,
    output logic       FlushD,
    output logic       FlushE,
    output logic       FlushM,
    output logic       MdBusy
);

    localparam int CW = (MD_LATENCY > 1) ? $clog2(MD_LATENCY) : 1;
    // MD_WAIT lasts MD_LATENCY-2 cycles; the counter runs down to 0 inclusive.
    localparam int LOAD = (MD_LATENCY > 2) ? (MD_LATENCY - 3) : 0;

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        MD_WAIT = 2'd1,
        MD_DONE = 2'd2
    } state_t;

    state_t        state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic          lw_stall;

    logic stall_f, stall_d, stall_e, flush_d, flush_e, flush_m, md_busy;

    assign lw_stall = MemReadE && (RD_E != 5'd0) &&
                      ((RD_E == Rs1_D) || (RD_E == Rs2_D));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= RUN;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        stall_f   = 1'b0;
        stall_d   = 1'b0;
        stall_e   = 1'b0;
        flush_d   = 1'b0;
        flush_e   = 1'b0;
        flush_m   = 1'b0;
        md_busy   = 1'b0;
        case (state)
            RUN: begin
                if (PCSrcE) begin
                    // Redirect wins: wrong-path instructions are squashed, so
                    // a pending load-use or mul/div on them is irrelevant.
                    flush_d = 1'b1;
                    flush_e = 1'b1;
                end else if (MdStartE) begin
                    stall_f = 1'b1;
                    stall_d = 1'b1;
                    stall_e = 1'b1;
                    flush_m = 1'b1;
                    if (MD_LATENCY > 2) begin
                        state_nxt = MD_WAIT;
                        cnt_nxt   = CW'(LOAD);
                    end else begin
                        state_nxt = MD_DONE;
                    end
                end else if (lw_stall) begin
                    stall_f = 1'b1;
                    stall_d = 1'b1;
                    flush_e = 1'b1;
                end
            end
            MD_WAIT: begin
                stall_f = 1'b1;
                stall_d = 1'b1;
                stall_e = 1'b1;
                flush_m = 1'b1;
                md_busy = 1'b1;
                if (cnt == '0) state_nxt = MD_DONE;
                else           cnt_nxt   = cnt - 1'b1;
            end
            MD_DONE: begin
                // Op leaves Execute at this edge; MdStartE still reflects it.
                md_busy   = 1'b1;
                state_nxt = RUN;
            end
            default: begin
                state_nxt = RUN;
                cnt_nxt   = '0;
            end
        endcase
    end

    // Outputs are forced low during reset even though RUN decodes live inputs.
    assign StallF = rst & stall_f;
    assign StallD = rst & stall_d;
    assign StallE = rst & stall_e;
    assign FlushD = rst & flush_d;
    assign FlushE = rst & flush_e;
    assign FlushM = rst & flush_m;
    assign MdBusy = rst & md_busy;

endmodule

// File: tb/tb_hazard_stall_unit.sv
// Directed bench for hazard_stall_unit. Three instances (MD_LATENCY 4, 2, 3)
// share the stimulus; each scenario checks the instance it targets.
// Output vectors are packed {StallF,StallD,StallE,FlushD,FlushE,FlushM,MdBusy}.
module tb_hazard_stall_unit;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] Rs1_D, Rs2_D, RD_E;
    logic       MemReadE, PCSrcE, MdStartE;

    logic [6:0] o4, o2, o3;
    int nchk = 0;
    int nerr = 0;

    always #5 clk = ~clk;

    hazard_stall_unit #(.MD_LATENCY(4)) u_dut4 (
        .clk(clk), .rst(rst), .Rs1_D(Rs1_D), .Rs2_D(Rs2_D), .RD_E(RD_E),
        .MemReadE(MemReadE), .PCSrcE(PCSrcE), .MdStartE(MdStartE),
        .StallF(o4[6]), .StallD(o4[5]), .StallE(o4[4]), .FlushD(o4[3]),
        .FlushE(o4[2]), .FlushM(o4[1]), .MdBusy(o4[0]));

    hazard_stall_unit #(.MD_LATENCY(2)) u_dut2 (
        .clk(clk), .rst(rst), .Rs1_D(Rs1_D), .Rs2_D(Rs2_D), .RD_E(RD_E),
        .MemReadE(MemReadE), .PCSrcE(PCSrcE), .MdStartE(MdStartE),
        .StallF(o2[6]), .StallD(o2[5]), .StallE(o2[4]), .FlushD(o2[3]),
        .FlushE(o2[2]), .FlushM(o2[1]), .MdBusy(o2[0]));

    hazard_stall_unit #(.MD_LATENCY(3)) u_dut3 (
        .clk(clk), .rst(rst), .Rs1_D(Rs1_D), .Rs2_D(Rs2_D), .RD_E(RD_E),
        .MemReadE(MemReadE), .PCSrcE(PCSrcE), .MdStartE(MdStartE),
        .StallF(o3[6]), .StallD(o3[5]), .StallE(o3[4]), .FlushD(o3[3]),
        .FlushE(o3[2]), .FlushM(o3[1]), .MdBusy(o3[0]));

    localparam logic [6:0] IDLE = 7'b000_000_0;
    localparam logic [6:0] LWS  = 7'b110_010_0;  // load-use stall
    localparam logic [6:0] BR   = 7'b000_110_0;  // branch redirect
    localparam logic [6:0] MDS  = 7'b111_001_0;  // md entry cycle
    localparam logic [6:0] MDW  = 7'b111_001_1;  // md wait
    localparam logic [6:0] MDD  = 7'b000_000_1;  // md done

    task automatic chk(input string tag, input logic [6:0] got, input logic [6:0] exp);
        nchk++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %b expected %b", tag, got, exp);
        end
    endtask

    // advance to just after the next rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input logic [4:0] r1, input logic [4:0] r2, input logic [4:0] rd,
                          input logic mr, input logic pc, input logic md);
        Rs1_D = r1; Rs2_D = r2; RD_E = rd;
        MemReadE = mr; PCSrcE = pc; MdStartE = md;
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        tick();
        set_in(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        rst = 1'b1;
        #1;
    endtask

    initial begin
        // reset with hostile inputs: outputs must stay low
        rst = 1'b0;
        set_in(5'd3, 5'd3, 5'd3, 1'b1, 1'b1, 1'b1);
        chk("rst_d4", o4, IDLE);
        chk("rst_d2", o2, IDLE);
        chk("rst_d3", o3, IDLE);
        tick();
        chk("rst_hold_d4", o4, IDLE);
        set_in(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        rst = 1'b1;
        tick();

        // load-use via Rs2, persists for two cycles
        set_in(5'd1, 5'd5, 5'd5, 1'b1, 1'b0, 1'b0);
        chk("lw_rs2", o4, LWS);
        tick();
        chk("lw_repeat", o4, LWS);
        // load-use via Rs1
        set_in(5'd9, 5'd2, 5'd9, 1'b1, 1'b0, 1'b0);
        chk("lw_rs1", o4, LWS);
        // x0 destination never stalls
        set_in(5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0);
        chk("lw_x0", o4, IDLE);
        // not a load
        set_in(5'd5, 5'd5, 5'd5, 1'b0, 1'b0, 1'b0);
        chk("no_load", o4, IDLE);
        // load without register match
        set_in(5'd4, 5'd6, 5'd5, 1'b1, 1'b0, 1'b0);
        chk("lw_nomatch", o4, IDLE);

        // branch beats load-use
        set_in(5'd7, 5'd1, 5'd7, 1'b1, 1'b1, 1'b0);
        chk("br_over_lw", o4, BR);
        // branch beats md start; machine stays in RUN
        set_in(5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b1);
        chk("br_over_md", o4, BR);
        tick();
        set_in(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        chk("br_md_run", o4, IDLE);
        chk("br_md_run2", o2, IDLE);
        tick();

        // MD_LATENCY=4, PCSrcE pulsed at c1, load-use at c2 both ignored
        set_in(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1);
        chk("md4_c0", o4, MDS);
        tick();
        set_in(5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b1);
        chk("md4_c1", o4, MDW);
        tick();
        set_in(5'd3, 5'd0, 5'd3, 1'b1, 1'b0, 1'b1);
        chk("md4_c2", o4, MDW);
        tick();
        set_in(5'd3, 5'd0, 5'd3, 1'b1, 1'b1, 1'b1);
        chk("md4_c3", o4, MDD);
        tick();
        set_in(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        chk("md4_c4", o4, IDLE);
        do_reset();

        // MD_LATENCY=2
        set_in(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1);
        chk("md2_c0", o2, MDS);
        tick();
        chk("md2_c1", o2, MDD);
        tick();
        set_in(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        chk("md2_c2", o2, IDLE);
        do_reset();

        // MD_LATENCY=3, two ops back to back
        set_in(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1);
        chk("md3_c0", o3, MDS);
        tick();
        chk("md3_c1", o3, MDW);
        tick();
        chk("md3_c2", o3, MDD);
        tick();
        chk("md3_c3", o3, MDS);
        tick();
        chk("md3_c4", o3, MDW);
        tick();
        chk("md3_c5", o3, MDD);
        tick();
        set_in(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        chk("md3_c6", o3, IDLE);
        do_reset();

        // async reset while in MD_WAIT
        set_in(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1);
        chk("mdr_c0", o4, MDS);
        tick();
        chk("mdr_c1", o4, MDW);
        #1;
        rst = 1'b0;
        #1;
        chk("mdr_async", o4, IDLE);
        tick();
        set_in(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        rst = 1'b1;
        #1;
        chk("mdr_release", o4, IDLE);
        tick();
        chk("mdr_idle", o4, IDLE);
        set_in(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1);
        chk("mdr_fresh", o4, MDS);
        tick();
        chk("mdr_fresh_c1", o4, MDW);
        set_in(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        tick();

        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end

endmodule

// File: doc/hazard_stall_unit.md
# hazard_stall_unit

Stall/flush controller for the 5-stage pipeline, the counterpart to the forwarding logic. The forwarding path resolves RAW hazards by bypassing; this block handles the hazards bypassing cannot: load-use dependencies, taken-branch redirects, and multi-cycle execute operations (mul/div) that must hold the Execute stage. It sits beside the pipeline registers and drives their enable (stall) and clear (flush) inputs.

## Interface

- MD_LATENCY, 4, cycles a multi-cycle op occupies Execute (legal 2..32)
- clk  in  1  pipeline clock, rising edge
- rst  in  1  asynchronous, active-low reset
- Rs1_D  in  5  source register 1 of instruction in Decode
- Rs2_D  in  5  source register 2 of instruction in Decode
- RD_E  in  5  destination register of instruction in Execute
- MemReadE  in  1  instruction in Execute is a load
- PCSrcE  in  1  taken branch/jump resolved in Execute
- MdStartE  in  1  instruction in Execute is a multi-cycle op; held high while it sits in Execute
- StallF  out  1  hold PC / Fetch register
- StallD  out  1  hold Decode register
- StallE  out  1  hold Execute register
- FlushD  out  1  clear Decode register
- FlushE  out  1  clear Execute register
- FlushM  out  1  clear Memory register (bubble insertion)
- MdBusy  out  1  multi-cycle sequence in progress (state != RUN)

## Operation

- States: RUN, MD_WAIT, MD_DONE. Counter cnt, width clog2(MD_LATENCY), unsigned.
- lwStall = MemReadE && RD_E != 0 && (RD_E == Rs1_D || RD_E == Rs2_D).
- RUN, priority highest first:
  - PCSrcE=1: FlushD=1, FlushE=1, all stalls 0, FlushM=0; MdStartE and lwStall ignored; stay RUN.
  - MdStartE=1: StallF=StallD=StallE=1, FlushM=1, FlushE=0. Next state MD_WAIT with cnt=MD_LATENCY-3 if MD_LATENCY>2, else MD_DONE.
  - lwStall=1: StallF=StallD=1, FlushE=1, others 0; stay RUN.
  - Otherwise all outputs 0.
- MD_WAIT: StallF=StallD=StallE=1, FlushM=1, FlushD=FlushE=0. If cnt==0, next MD_DONE; else cnt decrements. PCSrcE, lwStall, MdStartE ignored.
- MD_DONE: all stall/flush outputs 0 (op advances to Memory at this edge); MdStartE ignored (it is still the same op); next RUN.
- FlushE is never asserted outside RUN; the held multi-cycle op is never cleared.
- MdBusy = 1 in MD_WAIT and MD_DONE, 0 in RUN.

## Timing

- Stall/flush outputs are combinational from inputs plus registered state; no added latency.
- Multi-cycle op: Execute residency exactly MD_LATENCY cycles; stalls asserted for MD_LATENCY-1 cycles (entry cycle + MD_LATENCY-2 MD_WAIT cycles), then one unstalled MD_DONE cycle.
- Load-use: one stall cycle per occurrence; if the condition persists, stall repeats each cycle.
- Reset (rst=0), asynchronous: state=RUN, cnt=0, every output 0 immediately and for the duration of reset, regardless of inputs. Reset mid-sequence aborts it; after release, MdStartE=1 starts a fresh sequence.
- RD_E==0 never causes a load-use stall.

## Test plan

- Load-use: MemReadE=1, RD_E=5, Rs2_D=5, state RUN -> StallF=StallD=FlushE=1, StallE=FlushD=FlushM=0; repeat with RD_E=0 -> all outputs 0.
- Branch priority: PCSrcE=1 with MemReadE=1, RD_E=Rs1_D=7 -> FlushD=FlushE=1, StallF=StallD=0.
- MD_LATENCY=4, MdStartE high 4 cycles (c0..c3) -> StallE=1 at c0,c1,c2, 0 at c3; MdBusy 0,1,1,1; RUN at c4; PCSrcE=1 pulsed at c1 has no effect.
- MD_LATENCY=2, MdStartE high 2 cycles -> StallE=1 at c0 only, MdBusy=1 at c1, RUN at c2.
- Back-to-back: two multi-cycle ops (MD_LATENCY=3), MdStartE high 6 cycles -> stalls at c0,c1,c3,c4; none at c2,c5.
- Reset in MD_WAIT: rst=0 asynchronously -> all outputs 0 before next clk edge, MdBusy=0; after release with MdStartE=0 -> no stalls.
